// File: rtl/dm_sync_param.sv
// Parametrised single-port data memory for the MEM stage: posedge reads/writes,
// byte-lane steering, load extension, misalignment detection and post-reset clearing.
module dm_sync_param #(
    parameter int ADDR_W    = 12,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, init_done_q;
    logic             rsp_valid_q, rsp_err_q, rsp_load_q;
    logic [1:0]       rsp_off_q, rsp_size_q;
    logic             rsp_uns_q;
    logic [31:0]      rd_word_q;

    logic [31:0]      mem [DEPTH];

    logic             accept, legal, st_en, ld_en, init_wr;
    logic [1:0]       off;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       be;
    logic [31:0]      st_data;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign off      = req_addr[1:0];
    assign word_idx = req_addr[ADDR_W-1:2];
    assign accept   = req_valid & req_ready_q;
    assign legal    = (req_size == 2'b00) ||
                      (req_size == 2'b01 && !off[0]) ||
                      (req_size == 2'b10 && off == 2'b00);
    assign st_en    = accept & req_we & legal;
    assign ld_en    = accept & ~req_we & legal;
    assign init_wr  = (state_q == S_INIT);
    assign cnt_d    = cnt_q + 1'b1;

    // Store data is replicated across lanes; the byte enables pick the destination.
    always_comb begin
        be      = 4'b0000;
        st_data = req_wdata;
        case (req_size)
            2'b00: begin
                be      = 4'b0001 << off;
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[cnt_q] <= '0;
        end else if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        if (ld_en) rd_word_q <= mem[word_idx];
        if (accept) begin
            rsp_off_q  <= off;
            rsp_size_q <= req_size;
            rsp_uns_q  <= req_unsigned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= S_RUN;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
            endcase
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & ~legal;
            rsp_load_q  <= ld_en;
        end
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? load_ext(rd_word_q, rsp_off_q, rsp_size_q, rsp_uns_q) : 32'h0;

endmodule

// File: tb/tb_dm_sync_param.sv
// Directed bench for dm_sync_param with a 16-word memory (ADDR_W=6, INIT_ZERO=1).
module tb_dm_sync_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    dm_sync_param #(.ADDR_W(6), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Present one request, let it be accepted, and return 1 ns after the edge.
    task automatic drive(input logic we, input logic [5:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b done=%b rdata=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 16 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_length: cycles=%0d done=%b, want 16 and 1", n, init_done);
        end
        drive(1'b0, 6'h3C, 2'b10, 1'b0, 32'h0);
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL init_cleared: valid=%b err=%b rdata=%h, want 1 0 00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_byte_lanes;
        vec_t v[5];
        v = '{'{1'b1, 6'h10, 2'b10, 1'b0, 32'h8899AABB, 1'b0, 32'h0},
              '{1'b0, 6'h10, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFFBB},
              '{1'b0, 6'h13, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFF88},
              '{1'b0, 6'h12, 2'b00, 1'b1, 32'h0, 1'b0, 32'h00000099},
              '{1'b0, 6'h11, 2'b00, 1'b1, 32'h0, 1'b0, 32'h000000AA}};
        for (int i = 0; i < 5; i++) begin
            drive(v[i].we, v[i].addr, v[i].size, v[i].uns, v[i].wd);
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                errors++;
                $display("FAIL byte_lanes[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
    endtask

    task automatic test_halfword;
        vec_t v[5];
        v = '{'{1'b1, 6'h12, 2'b01, 1'b0, 32'hCAFE1234, 1'b0, 32'h0},
              '{1'b0, 6'h10, 2'b10, 1'b1, 32'h0, 1'b0, 32'h1234AABB},
              '{1'b0, 6'h10, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFFAABB},
              '{1'b0, 6'h10, 2'b01, 1'b1, 32'h0, 1'b0, 32'h0000AABB},
              '{1'b0, 6'h12, 2'b01, 1'b0, 32'h0, 1'b0, 32'h00001234}};
        for (int i = 0; i < 5; i++) begin
            drive(v[i].we, v[i].addr, v[i].size, v[i].uns, v[i].wd);
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                errors++;
                $display("FAIL halfword[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
    endtask

    task automatic test_misalign;
        vec_t v[9];
        v = '{'{1'b1, 6'h11, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0},
              '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1234AABB},
              '{1'b0, 6'h13, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b0, 6'h10, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b1, 6'h10, 2'b11, 1'b0, 32'h55555555, 1'b1, 32'h0},
              '{1'b1, 6'h12, 2'b10, 1'b0, 32'h66666666, 1'b1, 32'h0},
              '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1234AABB},
              '{1'b1, 6'h15, 2'b00, 1'b0, 32'hFFFFFF77, 1'b0, 32'h0},
              '{1'b0, 6'h14, 2'b10, 1'b0, 32'h0, 1'b0, 32'h00007700}};
        for (int i = 0; i < 9; i++) begin
            drive(v[i].we, v[i].addr, v[i].size, v[i].uns, v[i].wd);
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                errors++;
                $display("FAIL misalign[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] val;
        for (int i = 0; i < 8; i++) begin
            val = 32'h0BAD0000 + (i / 2) * 32'h01010101;
            if (i % 2 == 0) drive(1'b1, 6'h20, 2'b10, 1'b0, val);
            else            drive(1'b0, 6'h20, 2'b10, 1'b0, 32'h0);
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, (i % 2 == 0) ? 32'h0 : val}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b err=%b rdata=%h, want 1 0 %h",
                         i, rsp_valid, rsp_err, rsp_rdata, (i % 2 == 0) ? 32'h0 : val);
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL idle_after_burst: valid=%b err=%b rdata=%h, want 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int spurious;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, init_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_in_init: ready=%b done=%b, want 0 0", req_ready, init_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL init_restart_len: cycles=%0d, want 16", n);
        end
        drive(1'b0, 6'h10, 2'b10, 1'b0, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL rsp_drop_on_reset: valid=%b err=%b rdata=%h, want 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        spurious = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) spurious++;
        end
        checks++;
        if (n !== 16 || spurious !== 0) begin
            errors++;
            $display("FAIL reset_pending: init_cycles=%0d responses=%0d, want 16 and 0", n, spurious);
        end
        drive(1'b0, 6'h10, 2'b10, 1'b0, 32'h0);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reinit_cleared: valid=%b err=%b rdata=%h, want 1 0 00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_halfword();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
